// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   - WORD_W_DEF / ADDR_W_DEF : default data and address widths.
//   - state_t                 : loader FSM encoding.
//     S_VERIFY is only reachable when LOADER_VERIFY_EN is defined.
package loader_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_VERIFY = 3'd2,
        S_DONE   = 3'd3,
        S_ERR    = 3'd4
    } state_t;

endpackage

// File: rtl/loader_sum.sv
// Clear/add accumulator with W-bit wrapping arithmetic.
//   clk, reset : clock and asynchronous active-high reset
//   clr        : zero the sum; takes priority over add
//   add        : add din into the sum on this edge
//   din        : value to add
//   sum        : registered running sum
//   sum_nxt    : sum + din, so a caller can compare against the total that includes this cycle's value
module loader_sum #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         add,
    input  logic [W-1:0] din,
    output logic [W-1:0] sum,
    output logic [W-1:0] sum_nxt
);

    always_comb sum_nxt = sum + din;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    sum <= '0;
        else if (clr) sum <= '0;
        else if (add) sum <= sum_nxt;
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: accepts program words over a valid/ready stream and
// writes them to consecutive memory addresses starting at base. It owns
// the memory bus while loading. It then hands the bus to the datapath and
// releases cpu_reset.
//
// Optional feature (macro LOADER_VERIFY_EN): after the last write, the
// loader reads back base..base+count-1 and compares the wrapping sum of the
// read-back words with the sum of the words it wrote.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, base         begin a load at base (honoured only in IDLE)
//   maxmem              highest valid memory address
//   memout              memory read data (only used by the verify pass)
//   in_valid/in_data/in_last, in_ready   program word stream
//   mar, mdr, mrw       registered memory bus outputs
//   bus_own, cpu_reset  bus ownership and downstream reset
//   done, error         sticky status flags
//   count               words written since the last start
module program_loader
    import loader_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] maxmem,
    input  logic [WORD_W-1:0] memout,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mar,
    output logic [WORD_W-1:0] mdr,
    output logic              mrw,
    output logic              bus_own,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] count
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              fits;

    assign in_ready = (state == S_LOAD);
    assign accept   = in_valid & in_ready;
    // The overflow check happens before the increment, so ptr == maxmem is still a legal write.
    assign fits     = (ptr <= maxmem);

`ifdef LOADER_VERIFY_EN
    // The verify walk has count+1 cycles.
    // vcnt == 0: the final write is still landing in memory.
    // vcnt == k: memout holds the word at base+k-1.
    logic [ADDR_W-1:0] vcnt;
    logic [ADDR_W-1:0] base_q;
    logic [WORD_W-1:0] wr_sum, wr_sum_nxt;
    logic [WORD_W-1:0] rd_sum, rd_sum_nxt;
    logic              sum_clr;

    assign sum_clr = (state == S_IDLE) && start;

    loader_sum #(.W(WORD_W)) u_wr_sum (
        .clk     (clk),
        .reset   (reset),
        .clr     (sum_clr),
        .add     (accept && fits),
        .din     (in_data),
        .sum     (wr_sum),
        .sum_nxt (wr_sum_nxt)
    );

    loader_sum #(.W(WORD_W)) u_rd_sum (
        .clk     (clk),
        .reset   (reset),
        .clr     (sum_clr),
        .add     ((state == S_VERIFY) && (vcnt != '0)),
        .din     (memout),
        .sum     (rd_sum),
        .sum_nxt (rd_sum_nxt)
    );

    logic unused_sum;
    assign unused_sum = ^{wr_sum_nxt, rd_sum};
`else
    logic unused_memout;
    assign unused_memout = ^memout;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    if (!fits) begin
                        state_nxt = S_ERR;
                    end else if (in_last) begin
`ifdef LOADER_VERIFY_EN
                        state_nxt = S_VERIFY;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
            end
`ifdef LOADER_VERIFY_EN
            S_VERIFY: begin
                // count >= 1 here, so the vcnt == 0 write-settle cycle never ends the walk.
                if (vcnt == count)
                    state_nxt = (rd_sum_nxt == wr_sum) ? S_DONE : S_ERR;
            end
`endif
            default: state_nxt = state;   // DONE and ERR leave only via reset
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr       <= '0;
            count     <= '0;
            mar       <= '0;
            mdr       <= '0;
            mrw       <= 1'b0;
            bus_own   <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            mrw <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr   <= base;
                        count <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept && fits) begin
                        mar   <= ptr;
                        mdr   <= in_data;
                        mrw   <= 1'b1;
                        ptr   <= ptr + 1'b1;
                        count <= count + 1'b1;
                    end
                end
`ifdef LOADER_VERIFY_EN
                S_VERIFY: mar <= (vcnt == '0) ? base_q : mar + 1'b1;
`endif
                default: ;
            endcase

            if (state != S_DONE && state_nxt == S_DONE) begin
                bus_own   <= 1'b0;
                cpu_reset <= 1'b0;
                done      <= 1'b1;
            end
            if (state != S_ERR && state_nxt == S_ERR)
                error <= 1'b1;
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vcnt   <= '0;
            base_q <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                vcnt   <= '0;
                base_q <= base;
            end else if (state == S_VERIFY) begin
                vcnt <= vcnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
    import loader_pkg::*;

`ifdef LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base = '0, maxmem = 16'h00FF;
    logic [15:0] memout;
    logic        in_valid = 1'b0, in_last = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, mrw, bus_own, cpu_reset, done, error;
    logic [15:0] mar, mdr, count;

    logic [15:0] mem [0:255];
    logic        clr_mem = 1'b0;
    logic        corrupt = 1'b0;
    logic [15:0] cur_base = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .maxmem(maxmem),
        .memout(memout), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .mar(mar), .mdr(mdr), .mrw(mrw), .bus_own(bus_own),
        .cpu_reset(cpu_reset), .done(done), .error(error), .count(count)
    );

    // Memory model: synchronous write, combinational read. It can fake a
    // corrupted word at base+1 for the verify test.
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int k = 0; k < 256; k++) mem[k] <= 16'hDEAD;
        end else if (mrw) begin
            mem[mar[7:0]] <= mdr;
        end
    end
    assign memout = (corrupt && mar == cur_base + 16'd1) ? 16'h0000 : mem[mar[7:0]];

    typedef struct {
        bit          rst;     // reset before the scenario
        logic [15:0] base;
        logic [15:0] maxmem;
        int          n;       // words offered
        bit          gap;     // in_valid toggles 1,0,1,...
        int          stpulse; // word index where a stray start is pulsed (-1 none)
        bit          corrupt;
        logic [15:0] exp_count;
        bit          exp_done;
        bit          exp_err;
        bit          exp_ovf; // ends by overflow
    } scen_t;

    logic [15:0] words [0:7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_rst_vals();
        chk("rst in_ready",  {31'd0, in_ready},  0);
        chk("rst mar",       {16'd0, mar},       0);
        chk("rst mdr",       {16'd0, mdr},       0);
        chk("rst mrw",       {31'd0, mrw},       0);
        chk("rst bus_own",   {31'd0, bus_own},   1);
        chk("rst cpu_reset", {31'd0, cpu_reset}, 1);
        chk("rst done",      {31'd0, done},      0);
        chk("rst error",     {31'd0, error},     0);
        chk("rst count",     {16'd0, count},     0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; clr_mem = 1'b1;
        #1 chk_rst_vals();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; clr_mem = 1'b0;
    endtask

    task automatic pulse_start(input logic [15:0] b);
        @(negedge clk);
        start = 1'b1; base = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input scen_t s);
        logic [15:0] ptr;
        int i, cyc, d;
        bit v, rdy, ended;
        if (s.rst) do_reset();
        maxmem = s.maxmem; cur_base = s.base; corrupt = s.corrupt;
        @(negedge clk);
        start = 1'b1; base = s.base;
        @(posedge clk);
        ptr = s.base; i = 0; cyc = 0; ended = 0;
        while (i < s.n && cyc < 200 && !ended) begin
            @(negedge clk);
            v        = !(s.gap && (cyc % 2 == 1));
            start    = (i == s.stpulse) && v;
            base     = start ? 16'h0040 : s.base;
            in_valid = v;
            in_data  = words[i];
            in_last  = (i == s.n - 1);
            rdy      = in_ready;
            @(posedge clk); #1;
            if (v && rdy) begin
                if (ptr <= s.maxmem) begin
                    chk("wr mrw", {31'd0, mrw}, 1);
                    chk("wr mar", {16'd0, mar}, {16'd0, ptr});
                    chk("wr mdr", {16'd0, mdr}, {16'd0, words[i]});
                    ptr++;
                    if (i == s.n - 1) ended = 1;
                end else begin
                    chk("ovf mrw",   {31'd0, mrw},   0);
                    chk("ovf error", {31'd0, error}, 1);
                    ended = 1;
                end
                i++;
            end else begin
                chk("idle mrw", {31'd0, mrw}, 0);
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        if (!ended) chk("load timeout", 0, 1);
        // Latency from the last accept edge to a sticky status flag.
        d = 0;
        while (!(done || error) && d < 100) begin
            @(posedge clk); #1; d++;
        end
        chk("status latency", d, (s.exp_ovf || !VER) ? 0 : s.n + 1);
        // A start pulse in DONE or ERR must be ignored.
        pulse_start(16'h0080);
        repeat (2) @(negedge clk);
        chk("end count",     {16'd0, count},     {16'd0, s.exp_count});
        chk("end done",      {31'd0, done},      {31'd0, s.exp_done});
        chk("end error",     {31'd0, error},     {31'd0, s.exp_err});
        chk("end cpu_reset", {31'd0, cpu_reset}, {31'd0, !s.exp_done});
        chk("end bus_own",   {31'd0, bus_own},   {31'd0, !s.exp_done});
        chk("end in_ready",  {31'd0, in_ready},  0);
        chk("end mrw",       {31'd0, mrw},       0);
        for (int k = 0; k < s.n; k++) begin
            logic [15:0] a;
            a = s.base + k[15:0];
            chk("mem", {16'd0, mem[a[7:0]]}, {16'd0, (a <= s.maxmem) ? words[k] : 16'hDEAD});
        end
        corrupt = 1'b0;
    endtask

    scen_t tbl [$];

    initial begin
        words[0] = 16'hB00C; words[1] = 16'hEA00; words[2] = 16'hB000; words[3] = 16'h1234;
        words[4] = 16'h5678; words[5] = 16'h9ABC; words[6] = 16'h0F0F; words[7] = 16'hF00D;

        //          rst base    maxmem  n  gap st  cor cnt    done err ovf
        tbl.push_back('{0, 16'h20, 16'hFF, 5, 0, -1, 0, 16'd5, 1, 0, 0}); // restart after mid reset
        tbl.push_back('{1, 16'h00, 16'hFF, 3, 0, -1, 0, 16'd3, 1, 0, 0}); // back-to-back
        tbl.push_back('{1, 16'h10, 16'hFF, 3, 1, -1, 0, 16'd3, 1, 0, 0}); // valid toggling
        tbl.push_back('{1, 16'h00, 16'h02, 4, 0, -1, 0, 16'd3, 0, 1, 1}); // overflow
        tbl.push_back('{1, 16'h30, 16'hFF, 3, 0,  1, 0, 16'd3, 1, 0, 0}); // start during LOAD
        tbl.push_back('{1, 16'h40, 16'hFF, 1, 0, -1, 0, 16'd1, 1, 0, 0}); // last on first word
        tbl.push_back('{1, 16'hFE, 16'hFF, 2, 0, -1, 0, 16'd2, 1, 0, 0}); // ptr == maxmem legal
`ifdef LOADER_VERIFY_EN
        tbl.push_back('{1, 16'h50, 16'hFF, 3, 0, -1, 1, 16'd3, 0, 1, 0}); // verify mismatch
`endif

        // Reset in the middle of a 5-word load: outputs return to reset values at once.
        do_reset();
        maxmem = 16'h00FF;
        pulse_start(16'h0000);
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = words[k]; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 chk_rst_vals();
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[j]) run(tbl[j]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
